avalon_median_window: RTL and testbench

Parametrised Avalon-MM slave that computes the median, minimum or maximum of a window of WIN unsigned samples of DATA_W bits. Software writes samples either directly into the window registers or through a shift-in PUSH port. It then starts a sequential odd-even transposition sort and reads back the selected order statistic, a status word and an optional interrupt. It replaces the fixed 5×8-bit median peripheral on the same bus.

---
 rtl/median_pkg.sv | 39 +++
 rtl/median_sort_core.sv | 88 ++++++++
 rtl/avalon_median_window.sv | 146 ++++++++++++++
 tb/tb_avalon_median_window.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants and types for the windowed median/min/max peripheral.
package median_pkg;

  // Word addresses on the bus
  localparam int ADDR_CTRL    = 0;
  localparam int ADDR_RESULT  = 1;
  localparam int ADDR_PUSH    = 2;
  localparam int ADDR_SAMPLE0 = 3;

  // CTRL write-field bit positions
  localparam int CTRL_START    = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_CLR_DONE = 4;

  // STATUS read-field bit positions
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_MODE_LSB = 2;
  localparam int STAT_IRQ_EN   = 4;
  localparam int STAT_PENDING  = 5;

  // Order statistic selected at the end of a sort; code 3 behaves as median
  typedef enum logic [1:0] {
    MODE_MEDIAN     = 2'd0,
    MODE_MIN        = 2'd1,
    MODE_MAX        = 2'd2,
    MODE_MEDIAN_ALT = 2'd3
  } sortMode_t;

  // Sort sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SORT   = 2'd2,
    ST_FINISH = 2'd3
  } sortState_t;

endpackage

// File: rtl/median_sort_core.sv
// Sequential odd-even transposition sorter: snapshots a window on load,
// runs WIN passes (one per cycle) and registers the selected order statistic.
module median_sort_core
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 5
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  load,
  input  logic [WIN*DATA_W-1:0] snapshot,
  input  sortMode_t             mode,
  output logic                  busy,
  output logic                  donePulse,
  output logic [DATA_W-1:0]     result
);

  localparam int PASS_W = $clog2(WIN);
  localparam int MID    = (WIN - 1) / 2;

  sortState_t        state;
  sortMode_t         modeLatched;
  logic [PASS_W-1:0] passCnt;
  logic [DATA_W-1:0] arr     [WIN];
  logic [DATA_W-1:0] arrNext [WIN];
  logic              passOdd;

  assign passOdd   = passCnt[0];
  assign busy      = (state != ST_IDLE);
  assign donePulse = (state == ST_FINISH);

  // One compare-exchange pass: even passes pair (0,1),(2,3)..., odd passes (1,2),(3,4)...
  always_comb begin
    // NOTE: every variable written here gets a full default first, so no path leaves it holding a stale value (no latch).
    arrNext = arr;
    for (int i = 0; i < WIN - 1; i++) begin
      // Strict greater-than keeps equal samples in place
      if ((((i % 2) == 1) == passOdd) && (arr[i] > arr[i+1])) begin
        arrNext[i]   = arr[i+1];
        arrNext[i+1] = arr[i];
      end
    end
  end

  // Sequencer: IDLE -> LOAD -> SORT x WIN -> FINISH -> IDLE, with the sort array and result
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= ST_IDLE;
      modeLatched <= MODE_MEDIAN;
      passCnt     <= '0;
      // NOTE: the sort array is a handful of flops, not a RAM, so it is cleared with the rest of the state.
      arr         <= '{default: '0};
      result      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        ST_IDLE: begin
          if (load) state <= ST_LOAD;
        end
        ST_LOAD: begin
          for (int i = 0; i < WIN; i++) arr[i] <= snapshot[i*DATA_W +: DATA_W];
          modeLatched <= mode;
          passCnt     <= '0;
          state       <= ST_SORT;
        end
        ST_SORT: begin
          arr <= arrNext;
          if (passCnt == PASS_W'(WIN - 1)) begin
            state <= ST_FINISH;
          end else begin
            passCnt <= passCnt + PASS_W'(1);
          end
        end
        ST_FINISH: begin
          case (modeLatched)
            MODE_MIN: result <= arr[0];
            MODE_MAX: result <= arr[WIN-1];
            default:  result <= arr[MID];
          endcase
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/avalon_median_window.sv
// Avalon-MM slave wrapping the window sorter: bus decode, sample/control
// registers, the one-deep PENDING request and the registered read port.
module avalon_median_window
  import median_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 5,
  parameter int ADDR_W = 5
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iChipSelect_n,
  input  logic              iWrite_n,
  input  logic              iRead_n,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [31:0]       iData,
  output logic [31:0]       oData,
  output logic              oIrq
);

  logic                  wrEn;
  logic                  rdEn;
  logic                  ctrlWrite;
  logic                  pushWrite;
  logic                  startReq;
  logic                  loadReq;
  logic                  coreBusy;
  logic                  coreFinish;
  logic [DATA_W-1:0]     coreResult;
  logic [DATA_W-1:0]     sampleReg [WIN];
  logic [WIN*DATA_W-1:0] snapshot;
  sortMode_t             mode;
  logic                  irqEn;
  logic                  done;
  logic                  pending;
  logic [31:0]           rdData;
  logic                  unusedData;

  assign wrEn      = !iChipSelect_n && !iWrite_n;
  assign rdEn      = !iChipSelect_n && !iRead_n;
  assign ctrlWrite = wrEn && (iAddress == ADDR_W'(ADDR_CTRL));
  assign pushWrite = wrEn && (iAddress == ADDR_W'(ADDR_PUSH));
  assign startReq  = (ctrlWrite && iData[CTRL_START]) || pushWrite;
  // A fresh request or a parked one launches a run only when the core is idle
  assign loadReq   = !coreBusy && (startReq || pending);
  assign oIrq      = done && irqEn;
  // Upper data bits beyond DATA_W carry nothing for this peripheral
  assign unusedData = ^iData;

  // Flatten the sample registers into the core's snapshot vector
  always_comb begin
    snapshot = '0;
    for (int i = 0; i < WIN; i++) snapshot[i*DATA_W +: DATA_W] = sampleReg[i];
  end

  // Sample window: PUSH shifts toward higher indices, direct writes hit one slot
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < WIN; i++) sampleReg[i] <= '0;
    end else if (pushWrite) begin
      for (int k = WIN - 1; k > 0; k--) sampleReg[k] <= sampleReg[k-1];
      sampleReg[0] <= iData[DATA_W-1:0];
    end else begin
      for (int i = 0; i < WIN; i++) begin
        if (wrEn && (iAddress == ADDR_W'(ADDR_SAMPLE0 + i))) sampleReg[i] <= iData[DATA_W-1:0];
      end
    end
  end

  // MODE and IRQ_EN are plain fields of every CTRL write
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      mode  <= MODE_MEDIAN;
      irqEn <= 1'b0;
    end else if (ctrlWrite) begin
      mode  <= sortMode_t'(iData[CTRL_MODE_LSB +: 2]);
      irqEn <= iData[CTRL_IRQ_EN];
    end
  end

  // DONE sets on FINISH, clears at launch or on CLR_DONE (a START in the same write wins)
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      done <= 1'b0;
    end else if (coreFinish) begin
      done <= 1'b1;
    end else if (loadReq) begin
      done <= 1'b0;
    end else if (ctrlWrite && iData[CTRL_CLR_DONE] && !iData[CTRL_START]) begin
      done <= 1'b0;
    end
  end

  // PENDING parks one request made while busy; further requests merge into it
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      pending <= 1'b0;
    end else if (loadReq) begin
      pending <= 1'b0;
    end else if (startReq && coreBusy) begin
      pending <= 1'b1;
    end
  end

  // Read mux: unmapped and write-only addresses return zero
  always_comb begin
    rdData = '0;
    if (iAddress == ADDR_W'(ADDR_CTRL)) begin
      rdData[STAT_BUSY]            = coreBusy;
      rdData[STAT_DONE]            = done;
      rdData[STAT_MODE_LSB +: 2]   = mode;
      rdData[STAT_IRQ_EN]          = irqEn;
      rdData[STAT_PENDING]         = pending;
    end else if (iAddress == ADDR_W'(ADDR_RESULT)) begin
      rdData[DATA_W-1:0] = coreResult;
    end else begin
      for (int i = 0; i < WIN; i++) begin
        if (iAddress == ADDR_W'(ADDR_SAMPLE0 + i)) rdData[DATA_W-1:0] = sampleReg[i];
      end
    end
  end

  // Registered read data, held between reads
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oData <= '0;
    end else if (rdEn) begin
      oData <= rdData;
    end
  end

  median_sort_core #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) uSortCore (
    .iClk      (iClk),
    .iReset_n  (iReset_n),
    .load      (loadReq),
    .snapshot  (snapshot),
    .mode      (mode),
    .busy      (coreBusy),
    .donePulse (coreFinish),
    .result    (coreResult)
  );

endmodule

// File: tb/tb_avalon_median_window.sv
// Directed bench for avalon_median_window (WIN=5, DATA_W=8, ADDR_W=5).
module tb_avalon_median_window;

  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iChipSelect_n = 1'b1;
  logic        iWrite_n = 1'b1;
  logic        iRead_n = 1'b1;
  logic [4:0]  iAddress = '0;
  logic [31:0] iData = '0;
  logic [31:0] oData;
  logic        oIrq;

  int total = 0;
  int bad = 0;

  avalon_median_window #(.DATA_W(8), .WIN(5), .ADDR_W(5)) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iChipSelect_n (iChipSelect_n),
    .iWrite_n      (iWrite_n),
    .iRead_n       (iRead_n),
    .iAddress      (iAddress),
    .iData         (iData),
    .oData         (oData),
    .oIrq          (oIrq)
  );

  always #5 iClk = ~iClk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Write lands on the posedge between the two negedges
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge iClk);
    iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iWrite_n = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge iClk);
    iChipSelect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iRead_n = 1'b1;
    d = oData;
  endtask

  task automatic write_window(input logic [7:0] s0, s1, s2, s3, s4);
    bus_write(5'd3, {24'd0, s0});
    bus_write(5'd4, {24'd0, s1});
    bus_write(5'd5, {24'd0, s2});
    bus_write(5'd6, {24'd0, s3});
    bus_write(5'd7, {24'd0, s4});
  endtask

  // Poll STATUS until DONE=1 and BUSY=0, bounded
  task automatic wait_done(input string name);
    logic [31:0] s;
    bit ok = 0;
    for (int n = 0; n < 60 && !ok; n++) begin
      bus_read(5'd0, s);
      if (s[1] && !s[0]) ok = 1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s: DONE never seen, last status %h", name, s); end
  endtask

  task automatic apply_reset();
    @(negedge iClk);
    iReset_n = 1'b0;
    repeat (2) @(negedge iClk);
    iReset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    total++; if (oData !== 32'h0) begin bad++; $display("FAIL reset_odata: got %h want 0", oData); end
    total++; if (oIrq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", oIrq); end
    bus_read(5'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", r); end
    bus_read(5'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", r); end
    bus_read(5'd7, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL reset_sample4: got %h want 0", r); end
  endtask

  task automatic test_median_modes();
    logic [31:0] r;
    int firstK = 0;
    write_window(8'd9, 8'd3, 8'd7, 8'd1, 8'd5);
    // START, MODE=median, IRQ_EN so oIrq mirrors DONE cycle by cycle
    bus_write(5'd0, 32'h09);
    for (int k = 1; k <= 10; k++) begin
      @(negedge iClk);
      if (oIrq && firstK == 0) firstK = k;
    end
    total++; if (firstK !== 7) begin bad++; $display("FAIL done_latency: got %0d want 7", firstK); end
    bus_read(5'd0, r);
    total++; if (r !== 32'h12) begin bad++; $display("FAIL median_status: got %h want 12", r); end
    bus_read(5'd1, r);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL median_result: got %0d want 5", r); end

    bus_write(5'd0, 32'h03);
    bus_read(5'd0, r);
    total++; if (r !== 32'h05) begin bad++; $display("FAIL busy_status: got %h want 05", r); end
    wait_done("min_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd1) begin bad++; $display("FAIL min_result: got %0d want 1", r); end

    bus_write(5'd0, 32'h05);
    wait_done("max_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd9) begin bad++; $display("FAIL max_result: got %0d want 9", r); end

    bus_write(5'd0, 32'h07);
    wait_done("mode3_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL mode3_result: got %0d want 5", r); end

    write_window(8'd4, 8'd4, 8'd4, 8'd2, 8'd4);
    bus_write(5'd0, 32'h01);
    wait_done("equal_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd4) begin bad++; $display("FAIL equal_result: got %0d want 4", r); end
  endtask

  task automatic test_push();
    logic [31:0] r;
    logic [7:0] expSamples [5] = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    apply_reset();
    bus_write(5'd2, 32'd10);
    bus_write(5'd2, 32'd20);
    bus_read(5'd0, r);
    total++; if (r !== 32'h21) begin bad++; $display("FAIL push_pending: got %h want 21", r); end
    bus_write(5'd2, 32'd30);
    bus_write(5'd2, 32'd40);
    bus_write(5'd2, 32'd50);
    repeat (40) @(negedge iClk);
    for (int i = 0; i < 5; i++) begin
      bus_read(5'(3 + i), r);
      total++;
      if (r !== {24'd0, expSamples[i]}) begin bad++; $display("FAIL push_sample%0d: got %0d want %0d", i, r, expSamples[i]); end
    end
    bus_read(5'd1, r);
    total++; if (r !== 32'd30) begin bad++; $display("FAIL push_result: got %0d want 30", r); end
    repeat (20) @(negedge iClk);
    bus_read(5'd0, r);
    total++; if (r !== 32'h02) begin bad++; $display("FAIL push_no_extra_run: got %h want 02", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    write_window(8'd9, 8'd3, 8'd7, 8'd1, 8'd5);
    bus_write(5'd0, 32'h05);
    bus_write(5'd3, 32'd255);
    bus_write(5'd0, 32'h05);
    bus_read(5'd0, r);
    total++; if (r !== 32'h29) begin bad++; $display("FAIL b2b_pending: got %h want 29", r); end
    bus_read(5'd1, r);
    total++; if (r !== 32'd9) begin bad++; $display("FAIL b2b_first_result: got %0d want 9", r); end
    wait_done("b2b_second_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd255) begin bad++; $display("FAIL b2b_second_result: got %0d want 255", r); end
    bus_read(5'd0, r);
    total++; if (r !== 32'h0A) begin bad++; $display("FAIL b2b_status: got %h want 0a", r); end

    // MODE rewritten mid-sort only affects the next run
    bus_write(5'd0, 32'h01);
    bus_write(5'd0, 32'h02);
    wait_done("mode_change_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL mode_change_result: got %0d want 5", r); end
    bus_read(5'd0, r);
    total++; if (r !== 32'h06) begin bad++; $display("FAIL mode_change_status: got %h want 06", r); end
  endtask

  task automatic test_reset_mid_sort();
    logic [31:0] r;
    bus_read(5'd1, r);
    bus_write(5'd0, 32'h09);
    @(negedge iClk);
    iReset_n = 1'b0;
    #1;
    total++; if (oData !== 32'h0) begin bad++; $display("FAIL midreset_odata: got %h want 0", oData); end
    total++; if (oIrq !== 1'b0) begin bad++; $display("FAIL midreset_irq: got %b want 0", oIrq); end
    @(negedge iClk);
    iReset_n = 1'b1;
    bus_read(5'd0, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL midreset_status: got %h want 0", r); end
    bus_read(5'd1, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL midreset_result: got %h want 0", r); end
    bus_read(5'd3, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL midreset_sample0: got %h want 0", r); end
    write_window(8'd9, 8'd3, 8'd7, 8'd1, 8'd5);
    bus_write(5'd0, 32'h09);
    wait_done("after_reset_done");
    bus_read(5'd1, r);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL after_reset_result: got %0d want 5", r); end
  endtask

  task automatic test_irq_and_unused();
    logic [31:0] r;
    total++; if (oIrq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", oIrq); end
    bus_write(5'd0, 32'h18);
    total++; if (oIrq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", oIrq); end
    bus_read(5'd0, r);
    total++; if (r !== 32'h10) begin bad++; $display("FAIL clr_done_status: got %h want 10", r); end
    bus_write(5'd31, 32'hFFFF_FFFF);
    bus_read(5'd31, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL unused_addr31: got %h want 0", r); end
    bus_read(5'd8, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL unused_addr8: got %h want 0", r); end
    bus_read(5'd2, r);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL push_reads_zero: got %h want 0", r); end
  endtask

  initial begin
    repeat (3) @(negedge iClk);
    iReset_n = 1'b1;
    test_reset();
    test_median_modes();
    test_push();
    test_back_to_back();
    test_reset_mid_sort();
    test_irq_and_unused();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
